// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU control register block: AXI-Lite FSM
// encoding, response codes, register word offsets and reset defaults.
package hpu_pkg;

  typedef enum logic [2:0] {
    ST_INI,
    ST_AW,
    ST_W,
    ST_AWW,
    ST_AR1,
    ST_AR2
  } axi_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word offsets, i.e. byte address bits [9:2]
  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h01;
  localparam logic [7:0] REG_ADDR_I    = 8'h02;
  localparam logic [7:0] REG_ADDR_J    = 8'h03;
  localparam logic [7:0] REG_CONTROL   = 8'h04;
  localparam logic [7:0] REG_REMAINDER = 8'h05;
  localparam logic [7:0] REG_ITEM_NUM  = 8'h06;
  localparam logic [7:0] REG_IRQ_EN    = 8'h07;
  localparam logic [7:0] REG_IRQ_STAT  = 8'h08;
  localparam logic [7:0] REG_INFO      = 8'h09;

  localparam int unsigned RST_ADDR_I    = 9;
  localparam int unsigned RST_ADDR_J    = 2;
  localparam int unsigned RST_REMAINDER = 20;
  localparam int unsigned RST_ITEM_NUM  = 1000;

  // Expand the 4-bit byte strobe into a 32-bit bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/hpu_ctrl_regs.sv
// AXI-Lite control/status register block for the HPU. Holds the loop bounds,
// item count and run/gen controls, and raises a done interrupt when the
// output stream finishes.
module hpu_ctrl_regs
  import hpu_pkg::*;
#(
  parameter int NUM_CORES = 32,
  parameter int LOOP_W    = 20,
  parameter int ITEM_W    = 16,
  localparam int REM_W    = $clog2(NUM_CORES)
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [31:0]       S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [31:0]       S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  input  logic [ITEM_W-1:0] item_a,
  input  logic              get_fin,
  input  logic              last_hs,
  output logic              run,
  output logic              gen,
  output logic [LOOP_W-1:0] addr_i,
  output logic [LOOP_W-1:0] addr_j,
  output logic [REM_W-1:0]  remainder,
  output logic [ITEM_W-1:0] item_memory_num,
  output logic [31:0]       control,
  output logic              irq
);

  localparam int unsigned REM_RST_VAL = RST_REMAINDER % NUM_CORES;

  axi_state_e        r_state, w_state_next;
  logic [9:0]        r_awaddr, r_araddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_run, r_gen, r_done, r_get_fin, r_irq_stat, r_irq_en, r_irq;
  logic [LOOP_W-1:0] r_addr_i, r_addr_j;
  logic [REM_W-1:0]  r_rem;
  logic [ITEM_W-1:0] r_item;
  logic [31:0]       r_control, r_rdata;

  logic [7:0]  w_wr_word;
  logic        w_wr_win, w_wr_ro, w_wr_locked, w_wr_en, w_busy;
  logic [31:0] w_wmask, w_wbits, w_rd_val;
  logic [1:0]  w_ctrl_new;
  logic        w_we_ctrl, w_run_rise;
  logic        w_unused_addr;

  assign w_unused_addr = ^{S_AXI_AWADDR[31:12], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:12], S_AXI_ARADDR[1:0]};

  // AXI-Lite handshake state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= ST_INI;
    else                r_state <= w_state_next;
  end

  // Next-state decode; a pending write beats a pending read in idle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INI: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) w_state_next = ST_AWW;
        else if (S_AXI_AWVALID)            w_state_next = ST_AW;
        else if (S_AXI_WVALID)             w_state_next = ST_W;
        else if (S_AXI_ARVALID)            w_state_next = ST_AR1;
      end
      ST_AW:   if (S_AXI_WVALID)  w_state_next = ST_AWW;
      ST_W:    if (S_AXI_AWVALID) w_state_next = ST_AWW;
      ST_AWW:  if (S_AXI_BREADY)  w_state_next = ST_INI;
      ST_AR1:  w_state_next = ST_AR2;
      ST_AR2:  if (S_AXI_RREADY)  w_state_next = ST_INI;
      default: w_state_next = ST_INI;
    endcase
  end

  assign S_AXI_AWREADY = (r_state == ST_INI) || (r_state == ST_W);
  assign S_AXI_WREADY  = (r_state == ST_INI) || (r_state == ST_AW);
  assign S_AXI_ARREADY = (r_state == ST_INI);
  assign S_AXI_BVALID  = (r_state == ST_AWW);
  assign S_AXI_RVALID  = (r_state == ST_AR2);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = r_rdata;

  // Latch address and data beats as their handshakes complete
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awaddr <= '0;
      r_araddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) r_awaddr <= S_AXI_AWADDR[11:2];
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (r_state == ST_INI && S_AXI_ARVALID && !S_AXI_AWVALID && !S_AXI_WVALID)
        r_araddr <= S_AXI_ARADDR[11:2];
    end
  end

  assign w_busy      = r_run | r_gen;
  assign w_wr_word   = r_awaddr[7:0];
  assign w_wr_win    = (r_awaddr[9:8] == 2'b00);
  assign w_wr_ro     = w_wr_win && (w_wr_word == REG_STATUS || w_wr_word == REG_INFO);
  assign w_wr_locked = w_wr_win && w_busy &&
                       (w_wr_word >= REG_ADDR_I) && (w_wr_word <= REG_ITEM_NUM);
  assign S_AXI_BRESP = (w_wr_ro || w_wr_locked) ? RESP_SLVERR : RESP_OKAY;
  assign w_wr_en     = (r_state == ST_AWW) && S_AXI_BREADY &&
                       w_wr_win && !w_wr_ro && !w_wr_locked;
  assign w_wmask     = strb_mask(r_wstrb);
  assign w_wbits     = r_wdata & w_wmask;
  assign w_we_ctrl   = w_wr_en && (w_wr_word == REG_CTRL);
  assign w_ctrl_new  = ({r_run, r_gen} & ~w_wmask[1:0]) | w_wbits[1:0];
  assign w_run_rise  = w_we_ctrl && w_ctrl_new[1] && !r_run;

  // Run/gen controls: a software CTRL write overrides the hardware auto-clears
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_run      <= 1'b0;
      r_gen      <= 1'b0;
      r_done     <= 1'b0;
      r_get_fin  <= 1'b0;
      r_irq_stat <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_we_ctrl) begin
        r_run <= w_ctrl_new[1];
        r_gen <= w_ctrl_new[0];
      end else begin
        if (last_hs) r_run <= 1'b0;
        if (r_gen && (item_a == r_item)) r_gen <= 1'b0;
      end
      if (w_run_rise)   r_done <= 1'b0;
      else if (last_hs) r_done <= 1'b1;
      if (w_run_rise)   r_get_fin <= 1'b0;
      else if (get_fin) r_get_fin <= 1'b1;
      if (last_hs)
        r_irq_stat <= 1'b1;
      else if (w_wr_en && w_wr_word == REG_IRQ_STAT && w_wbits[0])
        r_irq_stat <= 1'b0;
      r_irq <= r_irq_stat & r_irq_en;
    end
  end

  // Plain configuration registers with per-byte strobes
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_addr_i  <= LOOP_W'(RST_ADDR_I);
      r_addr_j  <= LOOP_W'(RST_ADDR_J);
      r_rem     <= REM_W'(REM_RST_VAL);
      r_item    <= ITEM_W'(RST_ITEM_NUM);
      r_control <= '0;
      r_irq_en  <= 1'b0;
    end else if (w_wr_en) begin
      case (w_wr_word)
        REG_ADDR_I:    r_addr_i  <= (r_addr_i & ~w_wmask[LOOP_W-1:0]) | w_wbits[LOOP_W-1:0];
        REG_ADDR_J:    r_addr_j  <= (r_addr_j & ~w_wmask[LOOP_W-1:0]) | w_wbits[LOOP_W-1:0];
        REG_CONTROL:   r_control <= (r_control & ~w_wmask) | w_wbits;
        REG_REMAINDER: r_rem     <= (r_rem & ~w_wmask[REM_W-1:0]) | w_wbits[REM_W-1:0];
        REG_ITEM_NUM:  r_item    <= (r_item & ~w_wmask[ITEM_W-1:0]) | w_wbits[ITEM_W-1:0];
        REG_IRQ_EN:    r_irq_en  <= (r_irq_en & ~w_wmask[0]) | w_wbits[0];
        default: ;
      endcase
    end
  end

  // Read mux over the captured read address; anything unmapped reads zero
  always_comb begin
    w_rd_val = '0;
    if (r_araddr[9:8] == 2'b00) begin
      case (r_araddr[7:0])
        REG_CTRL:      w_rd_val = {30'd0, r_run, r_gen};
        REG_STATUS:    w_rd_val = {29'd0, r_get_fin, w_busy, r_done};
        REG_ADDR_I:    w_rd_val = 32'(r_addr_i);
        REG_ADDR_J:    w_rd_val = 32'(r_addr_j);
        REG_CONTROL:   w_rd_val = r_control;
        REG_REMAINDER: w_rd_val = 32'(r_rem);
        REG_ITEM_NUM:  w_rd_val = 32'(r_item);
        REG_IRQ_EN:    w_rd_val = {31'd0, r_irq_en};
        REG_IRQ_STAT:  w_rd_val = {31'd0, r_irq_stat};
        REG_INFO:      w_rd_val = {24'd0, 8'(NUM_CORES)};
        default:       w_rd_val = '0;
      endcase
    end
  end

  // Read data is sampled once in AR1 and then held for the R handshake
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)          r_rdata <= '0;
    else if (r_state == ST_AR1)  r_rdata <= w_rd_val;
  end

  assign run             = r_run;
  assign gen             = r_gen;
  assign addr_i          = r_addr_i;
  assign addr_j          = r_addr_j;
  assign remainder       = r_rem;
  assign item_memory_num = r_item;
  assign control         = r_control;
  assign irq             = r_irq;

endmodule

// File: doc/hpu_ctrl_regs.md
HPU_CTRL_REGS -- requirements
Module: hpu_ctrl_regs

Interface
REQ-001 SHALL have parameter NUM_CORES, default 32, number of HV cores (power of two, 2..64).
REQ-002 SHALL have parameter LOOP_W, default 20, width of the addr_i and addr_j loop bounds.
REQ-003 SHALL have parameter ITEM_W, default 16, width of the item-memory count.
REQ-004 SHALL have ports: S_AXI_ACLK in 1 clock; S_AXI_ARESETN in 1 reset; one clock, reset asynchronous active-low.
REQ-005 SHALL have AXI-Lite slave ports S_AXI_AW*/W*/B*/AR*/R*, with ADDR 32-bit (bits 11:2 decoded), DATA 32-bit, WSTRB 4-bit, BRESP/RRESP 2-bit.
REQ-006 SHALL have ports: item_a in ITEM_W, generation counter; get_fin in 1, pulse meaning all input consumed; last_hs in 1, pulse on output TLAST handshake.
REQ-007 SHALL have outputs run 1, gen 1, addr_i LOOP_W, addr_j LOOP_W, remainder log2(NUM_CORES), item_memory_num ITEM_W, control 32, irq 1.

Function
REQ-008 AXI-Lite FSM SHALL use states INI, AW, W, AWW, AR1, AR2.
REQ-009 INI: AW+W valid goes to AWW; AW only goes to AW; W only goes to W; AR only goes to AR1. Write has priority over read.
REQ-010 AW to AWW on WVALID. W to AWW on AWVALID. AWW to INI on BREADY. AR1 to AR2 unconditionally. AR2 to INI on RREADY.
REQ-011 Ready/valid mapping SHALL be: AWREADY=INI|W, WREADY=INI|AW, ARREADY=INI, BVALID=AWW, RVALID=AR2.
REQ-012 Register window SHALL be addr[11:10]==0; writes outside the window have no effect and return OKAY; reads outside the window return 0 with OKAY.
REQ-013 Register map (offsets):
- 0x00 CTRL {run,gen}
- 0x04 STATUS RO {busy=run|gen, done}
- 0x08 ADDR_I
- 0x0C ADDR_J
- 0x10 CONTROL scratch
- 0x14 REMAINDER
- 0x18 ITEM_NUM
- 0x1C IRQ_EN
- 0x20 IRQ_STAT W1C {done}
- 0x24 INFO RO {NUM_CORES[7:0]}
REQ-014 Writes SHALL honour WSTRB per byte; fields narrower than 32 bits take the low bits only.
REQ-015 Writes to 0x08–0x18 while run|gen=1 SHALL be dropped and answered with BRESP=SLVERR (2'b10); writes to RO offsets SHALL return SLVERR; all other writes return OKAY.
REQ-016 Write side effects SHALL occur in the AWW cycle that has BREADY=1, exactly once per transaction.
REQ-017 RDATA SHALL be captured in AR1 and held stable through AR2; unmapped offsets read 0; RRESP is always OKAY.
REQ-018 gen SHALL auto-clear in the cycle after the first cycle where gen=1 and item_a==item_memory_num.
REQ-019 run SHALL auto-clear on last_hs=1; done SHALL set on the same edge.
REQ-020 A software CTRL write and an auto-clear in the same cycle SHALL resolve with the software write taking priority.
REQ-021 IRQ_STAT.done SHALL set on the done event, clear on W1C; a set and a clear in the same cycle SHALL leave it set.
REQ-022 irq SHALL equal IRQ_STAT.done & IRQ_EN[0], registered.
REQ-023 get_fin SHALL be reflected in STATUS bit 2 (sticky until next run 0-to-1).
REQ-024 Writing CTRL run 0-to-1 SHALL clear STATUS.done and bit 2.

Reset
REQ-025 SHALL reset asynchronously to: state=INI, run=gen=0, addr_i=9, addr_j=2, remainder=20 mod NUM_CORES, item_memory_num=1000, control=0, IRQ_EN=0, IRQ_STAT=0, done=0, irq=0, RDATA=0.
REQ-026 Reset asserted mid-transaction SHALL abort it; no BVALID/RVALID SHALL be asserted after reset release without a new address phase.

Structure
REQ-027 Package hpu_pkg SHALL hold register offsets, the BRESP codes (OKAY/SLVERR), reset defaults, and the FSM state encoding.
REQ-028 Single module; no sub-module; the register decode is a case over addr[9:2].

Verification
REQ-029 Write 0x08=0x15 with AW and W simultaneous -> BRESP=OKAY; a read of 0x08 returns 0x15.
REQ-030 W one cycle before AW, WSTRB=4'b0001, data 0xAABBCC07 to 0x14 -> remainder=7, other bytes unchanged.
REQ-031 Set gen=1, item_memory_num=5, drive item_a 0..5 -> gen falls the cycle after item_a==5; CTRL reads 0.
REQ-032 With run=1, write 0x18=3 -> BRESP=SLVERR and ITEM_NUM unchanged (1000).
REQ-033 IRQ_EN=1, run=1, pulse last_hs -> run=0, STATUS.done=1, irq=1 next cycle; W1C 0x20=1 -> irq=0; a concurrent last_hs keeps it at 1.
REQ-034 Assert reset during AWW with BREADY=0 -> BVALID drops immediately; all registers return to REQ-025 values.
